// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    REQ  = 2'd2,
    SEND = 2'd3
  } txq_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer bringing a single transmitter-domain bit into the clk domain.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte FIFO plus start/busy/done handshake feeding the baud-domain UART transmitter.
// Define UART_TXQ_IRQ_EN to add the low-water/overflow irq output.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOW_WATER   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [UART_DATA_W-1:0]   wr_data,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic                     idle,
  output logic                     tx_start,
  output logic [UART_DATA_W-1:0]   tx_data,
  input  logic                     tx_busy,
  input  logic                     tx_done
`ifdef UART_TXQ_IRQ_EN
  ,
  output logic                     irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic busy_s, done_s, done_q, done_rise;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync_busy (
    .clk(clk), .rst_n(rst_n), .d_i(tx_busy), .q_o(busy_s)
  );

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync_done (
    .clk(clk), .rst_n(rst_n), .d_i(tx_done), .q_o(done_s)
  );

  assign done_rise = done_s & ~done_q;

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;

  txq_state_t             state_q;
  logic                   tx_start_q;
  logic [UART_DATA_W-1:0] tx_data_q;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == PW'(DEPTH));
  assign empty = (wr_ptr_q == rd_ptr_q);

  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign pop  = (state_q == LOAD) && !empty;
  assign push = wr_en && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && full && !pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // The IDLE busy check keeps a new start from overlapping a frame still on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= done_s;
      case (state_q)
        IDLE: if (!empty && !busy_s) state_q <= LOAD;
        LOAD: begin
          if (!empty) begin
            tx_data_q  <= mem[rd_ptr_q[AW-1:0]];
            tx_start_q <= 1'b1;
            state_q    <= REQ;
          end else begin
            state_q <= IDLE;
          end
        end
        REQ: begin
          if (busy_s) begin
            tx_start_q <= 1'b0;
            state_q    <= SEND;
          end
        end
        SEND: if (done_rise) state_q <= IDLE;
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign ovf      = ovf_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign idle     = empty && (state_q == IDLE) && !busy_s;

`ifdef UART_TXQ_IRQ_EN
  localparam logic [PW-1:0] LOW_WATER_L = PW'(LOW_WATER);
  logic irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= (level <= LOW_WATER_L) || ovf_q;
  end

  assign irq = irq_q;
`else
  logic unused_low_water;
  assign unused_low_water = (LOW_WATER == 0);
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue with a behavioural baud-domain transmitter model.
module tb_uart_tx_queue;

  localparam int FRAME = 6;

  logic       clk = 1'b0;
  logic       baudClk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       full, empty, ovf, idle, tx_start;
  logic [4:0] level;
  logic [7:0] tx_data;
  logic       tx_busy, tx_done;
`ifdef UART_TXQ_IRQ_EN
  logic       irq;
`endif

  int tests = 0;
  int failed = 0;

  logic       stall = 1'b0;
  logic       mSamp = 1'b0, mS1 = 1'b0, mS2 = 1'b0;
  logic       mBusy = 1'b0, mDone = 1'b0;
  int         mCnt = 0;
  logic [7:0] sentQ[$];
  logic [7:0] expQ[$];

  always #5 clk = ~clk;
  always #40 baudClk = ~baudClk;

  uart_tx_queue #(.DEPTH(16), .SYNC_STAGES(2), .LOW_WATER(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .full(full), .empty(empty), .level(level), .ovf(ovf), .idle(idle),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done)
`ifdef UART_TXQ_IRQ_EN
    , .irq(irq)
`endif
  );

  // Transmitter model: edge-detects start in its own clock, sends a frame, pulses done.
  always @(posedge baudClk) begin
    mSamp <= tx_start;
    mS1   <= mSamp;
    mS2   <= mS1;
    mDone <= 1'b0;
    if (mBusy) begin
      if (mCnt == 1) begin
        mBusy <= 1'b0;
        mDone <= 1'b1;
      end
      mCnt <= mCnt - 1;
    end else if (mS1 && !mS2 && !stall) begin
      mBusy <= 1'b1;
      mCnt  <= FRAME;
      sentQ.push_back(tx_data);
    end
  end

  assign tx_busy = mBusy | stall;
  assign tx_done = mDone;

  task automatic pushByte(input logic [7:0] b);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulseFlush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (idle) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitSent(input int n, input int maxCycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (sentQ.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || empty !== 1'b1 || full !== 1'b0 ||
        level !== 5'd0 || ovf !== 1'b0) begin
      failed++;
      $display("[TB] FAIL reset_outputs: start=%b data=%h empty=%b full=%b level=%0d ovf=%b, required 0 00 1 0 0 0",
               tx_start, tx_data, empty, full, level, ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (idle !== 1'b1) begin
      failed++;
      $display("[TB] FAIL reset_idle: idle=%b, required 1", idle);
    end
  endtask

  task automatic test_single();
    bit ok;
    sentQ.delete();
    pushByte(8'hA5);
    tests++;
    if (empty !== 1'b0 || tx_start !== 1'b0) begin
      failed++;
      $display("[TB] FAIL single_n: empty=%b start=%b, required 0 0", empty, tx_start);
    end
    @(negedge clk);
    tests++;
    if (tx_start !== 1'b0) begin
      failed++;
      $display("[TB] FAIL single_n1: start=%b, required 0", tx_start);
    end
    @(negedge clk);
    tests++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
      failed++;
      $display("[TB] FAIL single_n2: start=%b data=%h, required 1 a5", tx_start, tx_data);
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      failed++;
      $display("[TB] FAIL single_start_drop: start=%b, required 0 within 100 cycles", tx_start);
    end
    waitIdle(400, ok);
    tests++;
    if (!ok || sentQ.size() != 1 || sentQ[0] !== 8'hA5) begin
      failed++;
      $display("[TB] FAIL single_sent: idle=%b count=%0d, required idle and one byte a5", idle, sentQ.size());
    end
  endtask

  task automatic test_fill_ovf();
    bit ok;
    sentQ.delete();
    @(negedge clk);
    stall = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      pushByte(8'(i));
      tests++;
      if (level !== 5'(i) || full !== (i == 16)) begin
        failed++;
        $display("[TB] FAIL fill_level_%0d: level=%0d full=%b, required %0d %b", i, level, full, i, (i == 16));
      end
    end
    pushByte(8'h99);
    tests++;
    if (ovf !== 1'b1 || level !== 5'd16 || full !== 1'b1) begin
      failed++;
      $display("[TB] FAIL fill_ovf: ovf=%b level=%0d full=%b, required 1 16 1", ovf, level, full);
    end
    @(negedge clk);
    stall = 1'b0;
    waitSent(16, 4000, ok);
    if (ok) waitIdle(400, ok);
    repeat (100) @(negedge clk);
    tests++;
    if (!ok || sentQ.size() != 16) begin
      failed++;
      $display("[TB] FAIL fill_count: sent=%0d, required 16", sentQ.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        tests++;
        if (sentQ[i] !== 8'(i + 1)) begin
          failed++;
          $display("[TB] FAIL fill_order_%0d: got %h, required %h", i, sentQ[i], 8'(i + 1));
        end
      end
    end
    tests++;
    if (empty !== 1'b1 || ovf !== 1'b1) begin
      failed++;
      $display("[TB] FAIL fill_after: empty=%b ovf=%b, required 1 1", empty, ovf);
    end
  endtask

  task automatic test_full_pop();
    bit ok;
    logic [7:0] b;
    pulseFlush();
    tests++;
    if (ovf !== 1'b0 || level !== 5'd0 || empty !== 1'b1) begin
      failed++;
      $display("[TB] FAIL flush_clears_ovf: ovf=%b level=%0d empty=%b, required 0 0 1", ovf, level, empty);
    end
    sentQ.delete();
    expQ.delete();
    @(negedge clk);
    stall = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      expQ.push_back(b);
      pushByte(b);
    end
    tests++;
    if (full !== 1'b1 || ovf !== 1'b0) begin
      failed++;
      $display("[TB] FAIL fullpop_pre: full=%b ovf=%b, required 1 0", full, ovf);
    end
    // busy_s clears two edges after release, LOAD follows one edge later
    @(negedge clk);
    stall = 1'b0;
    repeat (3) @(negedge clk);
    b = 8'($urandom);
    expQ.push_back(b);
    wr_en = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
    tests++;
    if (level !== 5'd16 || full !== 1'b1 || ovf !== 1'b0 || tx_start !== 1'b1) begin
      failed++;
      $display("[TB] FAIL fullpop_same_cycle: level=%0d full=%b ovf=%b start=%b, required 16 1 0 1",
               level, full, ovf, tx_start);
    end
    waitSent(17, 4000, ok);
    if (ok) waitIdle(400, ok);
    tests++;
    if (!ok || sentQ.size() != 17) begin
      failed++;
      $display("[TB] FAIL fullpop_count: sent=%0d, required 17", sentQ.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        tests++;
        if (sentQ[i] !== expQ[i]) begin
          failed++;
          $display("[TB] FAIL fullpop_order_%0d: got %h, required %h", i, sentQ[i], expQ[i]);
        end
      end
    end
  endtask

  task automatic test_flush();
    bit ok;
    sentQ.delete();
    pushByte(8'h3C);
    waitSent(1, 200, ok);
    tests++;
    if (!ok) begin
      failed++;
      $display("[TB] FAIL flush_first_capture: sent=%0d, required 1", sentQ.size());
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) pushByte(8'($urandom));
    tests++;
    if (level !== 5'd5) begin
      failed++;
      $display("[TB] FAIL flush_queued: level=%0d, required 5", level);
    end
    @(negedge clk);
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    @(negedge clk);
    flush = 1'b0;
    wr_en = 1'b0;
    tests++;
    if (level !== 5'd0 || empty !== 1'b1 || ovf !== 1'b0) begin
      failed++;
      $display("[TB] FAIL flush_cleared: level=%0d empty=%b ovf=%b, required 0 1 0", level, empty, ovf);
    end
    waitIdle(400, ok);
    repeat (200) @(negedge clk);
    tests++;
    if (!ok || sentQ.size() != 1 || sentQ[0] !== 8'h3C) begin
      failed++;
      $display("[TB] FAIL flush_inflight: sent=%0d first=%h, required 1 byte 3c",
               sentQ.size(), (sentQ.size() > 0) ? sentQ[0] : 8'h00);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] b;
    sentQ.delete();
    expQ.delete();
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 30)) @(negedge clk);
      b = 8'($urandom);
      expQ.push_back(b);
      pushByte(b);
    end
    waitSent(12, 4000, ok);
    if (ok) waitIdle(400, ok);
    tests++;
    if (!ok || sentQ.size() != 12 || ovf !== 1'b0) begin
      failed++;
      $display("[TB] FAIL random_count: sent=%0d ovf=%b, required 12 0", sentQ.size(), ovf);
    end else begin
      for (int i = 0; i < 12; i++) begin
        tests++;
        if (sentQ[i] !== expQ[i]) begin
          failed++;
          $display("[TB] FAIL random_order_%0d: got %h, required %h", i, sentQ[i], expQ[i]);
        end
      end
    end
  endtask

`ifdef UART_TXQ_IRQ_EN
  task automatic test_irq();
    pulseFlush();
    @(negedge clk);
    stall = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      pushByte(8'($urandom));
      @(negedge clk);
      tests++;
      if (irq !== (i <= 2)) begin
        failed++;
        $display("[TB] FAIL irq_level_%0d: irq=%b, required %b", i, irq, (i <= 2));
      end
    end
    pushByte(8'h77);
    @(negedge clk);
    tests++;
    if (irq !== 1'b1 || ovf !== 1'b1) begin
      failed++;
      $display("[TB] FAIL irq_ovf: irq=%b ovf=%b, required 1 1", irq, ovf);
    end
    pulseFlush();
    @(negedge clk);
    stall = 1'b0;
    repeat (20) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid_req();
    bit ok;
    bit sawStart;
    sentQ.delete();
    pushByte(8'($urandom));
    repeat (2) @(negedge clk);
    tests++;
    if (tx_start !== 1'b1) begin
      failed++;
      $display("[TB] FAIL midreq_start: start=%b, required 1", tx_start);
    end
    stall = 1'b1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || level !== 5'd0 || empty !== 1'b1) begin
      failed++;
      $display("[TB] FAIL midreq_reset: start=%b data=%h level=%0d empty=%b, required 0 00 0 1",
               tx_start, tx_data, level, empty);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sentQ.delete();
    pushByte(8'h5A);
    sawStart = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_start) sawStart = 1'b1;
    end
    tests++;
    if (sawStart) begin
      failed++;
      $display("[TB] FAIL midreq_hold: start seen=%b while busy, required 0", sawStart);
    end
    stall = 1'b0;
    waitSent(1, 1000, ok);
    if (ok) waitIdle(400, ok);
    tests++;
    if (!ok || sentQ.size() != 1 || sentQ[0] !== 8'h5A) begin
      failed++;
      $display("[TB] FAIL midreq_fresh: sent=%0d first=%h, required 1 byte 5a",
               sentQ.size(), (sentQ.size() > 0) ? sentQ[0] : 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_ovf();
    test_full_pop();
    test_flush();
    test_random();
`ifdef UART_TXQ_IRQ_EN
    test_irq();
`endif
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
